// File: rtl/midi_byte_arbiter.sv
// midi_byte_arbiter
// Shares the MIDI byte-trigger path between the live UART parser and the
// internal sysex/patch generator. Whole messages are granted, bytes are
// spaced so the downstream trigger chain can settle, a starved generator is
// forced in after a run of live messages, and a stalled owner is aborted.
//
//  state | meaning
//  ------+-------------------------------------------------------------
//  IDLE  | no owner; arbitrate between pending sources
//  GRANT | owner's ready high, waiting for its next byte (stall timer runs)
//  EMIT  | byteready pulse for the byte accepted in GRANT
//  GAP   | settle time after every byte; then next byte or back to IDLE

module midi_byte_arbiter #(
    parameter int unsigned GAP_CYCLES     = 6,
    parameter int unsigned STALL_TIMEOUT  = 1024,
    parameter int unsigned MAX_LIVE_BURST = 4
) (
    input  logic       reg_clk,
    input  logic       reset_reg,
    input  logic       live_valid,
    input  logic [7:0] live_data,
    input  logic       live_last,
    output logic       live_ready,
    input  logic       gen_valid,
    input  logic [7:0] gen_data,
    input  logic       gen_last,
    output logic       gen_ready,
    output logic       byteready,
    output logic [7:0] midi_in_data,
    output logic [7:0] midibyte_nr,
    output logic       is_st_sysex,
    output logic       grant_gen,
    output logic       busy,
    output logic       abort_pulse
);

    localparam int unsigned GAP_W   = $clog2(GAP_CYCLES + 1);
    localparam int unsigned STALL_W = (STALL_TIMEOUT > 1) ? $clog2(STALL_TIMEOUT) : 1;
    localparam int unsigned BURST_W = $clog2(MAX_LIVE_BURST + 1);

    localparam logic [GAP_W-1:0]   GAP_LOAD   = GAP_W'(GAP_CYCLES);
    localparam logic [GAP_W-1:0]   GAP_ONE    = GAP_W'(1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_TIMEOUT - 1);
    localparam logic [BURST_W-1:0] BURST_MAX  = BURST_W'(MAX_LIVE_BURST);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        EMIT  = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t               state;
    state_t               state_nxt;

    logic [7:0]           byte_idx;
    logic                 last_flag;
    logic [GAP_W-1:0]     gap_cnt;
    logic [STALL_W-1:0]   stall_cnt;
    logic [BURST_W-1:0]   burst_cnt;

    logic                 any_valid;
    logic                 choose_gen;
    logic                 owner_valid;
    logic [7:0]           owner_data;
    logic                 owner_last;
    logic                 arbitrate;
    logic                 accept;
    logic                 stall_expire;
    logic                 gap_done;
    logic                 msg_done;

    // Source selection: the generator only wins a contested arbitration once
    // live has had MAX_LIVE_BURST consecutive messages while gen was waiting.
    assign any_valid    = live_valid | gen_valid;
    assign choose_gen   = gen_valid & (~live_valid | (burst_cnt == BURST_MAX));

    assign owner_valid  = grant_gen ? gen_valid : live_valid;
    assign owner_data   = grant_gen ? gen_data  : live_data;
    assign owner_last   = grant_gen ? gen_last  : live_last;

    assign arbitrate    = (state == IDLE) & any_valid;
    assign accept       = (state == GRANT) & owner_valid;
    assign stall_expire = (state == GRANT) & ~owner_valid & (stall_cnt == STALL_LAST);
    assign gap_done     = (state == GAP) & (gap_cnt == GAP_ONE);
    assign msg_done     = gap_done & last_flag;

    // State register.
    always_ff @(posedge reg_clk or posedge reset_reg) begin
        if (reset_reg) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (any_valid) begin
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (owner_valid) begin
                    state_nxt = EMIT;
                end else if (stall_cnt == STALL_LAST) begin
                    state_nxt = IDLE;
                end
            end
            EMIT: begin
                state_nxt = GAP;
            end
            GAP: begin
                if (gap_cnt == GAP_ONE) begin
                    state_nxt = last_flag ? IDLE : GRANT;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Handshake and status outputs decoded from the current state.
    always_comb begin
        live_ready = 1'b0;
        gen_ready  = 1'b0;
        byteready  = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
            end
            GRANT: begin
                live_ready = ~grant_gen;
                gen_ready  = grant_gen;
            end
            EMIT: begin
                byteready = 1'b1;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

    // Owner flag: set at arbitration, dropped when the message ends or aborts.
    always_ff @(posedge reg_clk or posedge reset_reg) begin
        if (reset_reg) begin
            grant_gen <= 1'b0;
        end else if (arbitrate) begin
            grant_gen <= choose_gen;
        end else if (msg_done | stall_expire) begin
            grant_gen <= 1'b0;
        end
    end

    // Byte latch: data and index are held from EMIT until the next accept.
    always_ff @(posedge reg_clk or posedge reset_reg) begin
        if (reset_reg) begin
            midi_in_data <= 8'h00;
            midibyte_nr  <= 8'h00;
            last_flag    <= 1'b0;
        end else if (accept) begin
            midi_in_data <= owner_data;
            midibyte_nr  <= byte_idx;
            last_flag    <= owner_last;
        end else if (stall_expire) begin
            midi_in_data <= 8'h00;
            midibyte_nr  <= 8'h00;
            last_flag    <= 1'b0;
        end
    end

    // Sysex flag follows the status byte of the message in flight.
    always_ff @(posedge reg_clk or posedge reset_reg) begin
        if (reset_reg) begin
            is_st_sysex <= 1'b0;
        end else if (accept && (byte_idx == 8'h00)) begin
            is_st_sysex <= (owner_data == 8'hF0);
        end else if (msg_done | stall_expire) begin
            is_st_sysex <= 1'b0;
        end
    end

    // Position within the message; saturates so long sysex dumps stay at 255.
    always_ff @(posedge reg_clk or posedge reset_reg) begin
        if (reset_reg) begin
            byte_idx <= 8'h00;
        end else if (state == IDLE) begin
            byte_idx <= 8'h00;
        end else if ((state == EMIT) && (byte_idx != 8'hFF)) begin
            byte_idx <= byte_idx + 8'd1;
        end
    end

    // Inter-byte spacing down-counter, loaded on the byteready cycle.
    always_ff @(posedge reg_clk or posedge reset_reg) begin
        if (reset_reg) begin
            gap_cnt <= '0;
        end else if (state == EMIT) begin
            gap_cnt <= GAP_LOAD;
        end else if ((state == GAP) && (gap_cnt != '0)) begin
            gap_cnt <= gap_cnt - GAP_ONE;
        end
    end

    // Stall timer counts owner-idle cycles in GRANT only.
    always_ff @(posedge reg_clk or posedge reset_reg) begin
        if (reset_reg) begin
            stall_cnt <= '0;
        end else if ((state == GRANT) && !owner_valid && !stall_expire) begin
            stall_cnt <= stall_cnt + STALL_W'(1);
        end else begin
            stall_cnt <= '0;
        end
    end

    // Live-burst counter, only touched when an arbitration actually happens.
    always_ff @(posedge reg_clk or posedge reset_reg) begin
        if (reset_reg) begin
            burst_cnt <= '0;
        end else if (arbitrate) begin
            if (choose_gen || !gen_valid) begin
                burst_cnt <= '0;
            end else if (burst_cnt != BURST_MAX) begin
                burst_cnt <= burst_cnt + BURST_W'(1);
            end
        end
    end

    // Abort strobe appears the cycle after the stall limit is hit.
    always_ff @(posedge reg_clk or posedge reset_reg) begin
        if (reset_reg) begin
            abort_pulse <= 1'b0;
        end else begin
            abort_pulse <= stall_expire;
        end
    end

endmodule

// File: tb/tb_midi_byte_arbiter.sv
// Testbench for midi_byte_arbiter: source drivers push the expected byte
// stream into a scoreboard as their bytes are taken; a negedge monitor pops
// and compares on every byteready.

module tb_midi_byte_arbiter;

    logic       reg_clk = 1'b0;
    logic       reset_reg;
    logic       live_valid, live_last, live_ready;
    logic [7:0] live_data;
    logic       gen_valid, gen_last, gen_ready;
    logic [7:0] gen_data;
    logic       byteready, is_st_sysex, grant_gen, busy, abort_pulse;
    logic [7:0] midi_in_data, midibyte_nr;

    midi_byte_arbiter dut (
        .reg_clk      (reg_clk),
        .reset_reg    (reset_reg),
        .live_valid   (live_valid),
        .live_data    (live_data),
        .live_last    (live_last),
        .live_ready   (live_ready),
        .gen_valid    (gen_valid),
        .gen_data     (gen_data),
        .gen_last     (gen_last),
        .gen_ready    (gen_ready),
        .byteready    (byteready),
        .midi_in_data (midi_in_data),
        .midibyte_nr  (midibyte_nr),
        .is_st_sysex  (is_st_sysex),
        .grant_gen    (grant_gen),
        .busy         (busy),
        .abort_pulse  (abort_pulse)
    );

    always #5 reg_clk = ~reg_clk;

    typedef logic [7:0] msg_t [$];
    typedef struct {
        logic [7:0] data;
        logic [7:0] idx;
        logic       sysex;
        logic       src;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   accept_log[$];
    int   br_log[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   last_push_cyc = 0;
    int   last_br = -1000;
    logic prev_src = 1'b0;

    always @(posedge reg_clk) cyc = cyc + 1;

    task automatic chk(input string name, input longint act, input longint expv);
        vectors++;
        if (act != expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor / scoreboard.
    always @(negedge reg_clk) begin : monitor
        exp_t e;
        if (reset_reg) begin
            last_br = -1000;
        end else begin
            chk("ready_exclusive", live_ready & gen_ready, 0);
            if (byteready) begin
                br_log.push_back(cyc);
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_byteready: data %0h nr %0h with empty scoreboard (cycle %0d)",
                             midi_in_data, midibyte_nr, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("data", midi_in_data, e.data);
                    chk("byte_nr", midibyte_nr, e.idx);
                    chk("sysex", is_st_sysex, e.sysex);
                    chk("grant_gen", grant_gen, e.src);
                    chk("latency", cyc, e.cyc);
                    chk("spacing_ge_8", (cyc - last_br) >= 8, 1);
                    if (e.idx != 8'h00) chk("contiguous_owner", e.src, prev_src);
                    prev_src = e.src;
                end
                last_br = cyc;
            end
        end
    end

    task automatic drop_valid(input bit src);
        if (src) gen_valid = 1'b0;
        else     live_valid = 1'b0;
    endtask

    task automatic drive_byte(input bit src, input logic [7:0] d, input logic l);
        if (src) begin gen_valid = 1'b1; gen_data = d; gen_last = l; end
        else     begin live_valid = 1'b1; live_data = d; live_last = l; end
    endtask

    // Wait (bounded) for the source's ready, then log the expected byte.
    task automatic wait_accept(input bit src, input msg_t msg, input int i, output bit ok);
        exp_t e;
        int n = 0;
        do begin
            @(negedge reg_clk);
            n++;
        end while (!(src ? gen_ready : live_ready) && n < 3000);
        ok = src ? gen_ready : live_ready;
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL handshake_timeout: src %0d byte %0d got no ready expected ready", src, i);
            return;
        end
        e.data  = msg[i];
        e.idx   = 8'((i > 255) ? 255 : i);
        e.sysex = (msg[0] == 8'hF0);
        e.src   = src;
        e.cyc   = cyc + 1;
        exp_q.push_back(e);
        last_push_cyc = cyc + 1;
        if (i == 0) accept_log.push_back(int'(src));
    endtask

    task automatic send_msg(input bit src, input msg_t msg, input int max_hold);
        bit ok;
        for (int i = 0; i < msg.size(); i++) begin
            drive_byte(src, msg[i], i == msg.size() - 1);
            wait_accept(src, msg, i, ok);
            if (!ok) begin
                drop_valid(src);
                return;
            end
            @(posedge reg_clk);
            #1;
            if (max_hold > 0 && i < msg.size() - 1 && $urandom_range(0, 1) == 1) begin
                drop_valid(src);
                repeat ($urandom_range(1, max_hold)) @(posedge reg_clk);
                #1;
            end
        end
        drop_valid(src);
    endtask

    task automatic wait_idle(output int drop_cyc, output logic sysex_before);
        int n = 0;
        sysex_before = is_st_sysex;
        forever begin
            @(negedge reg_clk);
            if (!busy || n > 200) break;
            sysex_before = is_st_sysex;
            n++;
        end
        drop_cyc = cyc;
    endtask

    function automatic msg_t rand_msg();
        msg_t m;
        int len = $urandom_range(1, 4);
        m.push_back(($urandom_range(0, 3) == 0) ? 8'hF0 : 8'($urandom_range(8'h80, 8'hEF)));
        for (int i = 1; i < len; i++) m.push_back(8'($urandom_range(0, 127)));
        return m;
    endfunction

    function automatic logic [22:0] all_outs();
        return {byteready, midi_in_data, midibyte_nr, is_st_sysex, grant_gen,
                busy, abort_pulse, live_ready, gen_ready};
    endfunction

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin : main
        msg_t m;
        int   drop_c, br_c, n;
        logic sx_before;
        bit   ok;
        int   exp_order[6] = '{0, 0, 0, 0, 1, 0};

        reset_reg = 1'b1;
        live_valid = 0; live_data = 0; live_last = 0;
        gen_valid = 0;  gen_data = 0;  gen_last = 0;
        repeat (3) @(posedge reg_clk);
        #1;
        chk("reset_outputs", all_outs(), 0);
        reset_reg = 1'b0;
        repeat (2) @(posedge reg_clk);
        #1;

        // Live note-on, three bytes.
        br_log.delete();
        m = {8'h90, 8'h3C, 8'h64};
        send_msg(0, m, 0);
        wait_idle(drop_c, sx_before);
        chk("live_pulse_count", br_log.size(), 3);
        if (br_log.size() == 3) begin
            chk("live_period_1", br_log[1] - br_log[0], 8);
            chk("live_period_2", br_log[2] - br_log[1], 8);
        end
        chk("live_busy_drop", drop_c - last_push_cyc, 7);

        // Generator sysex message.
        m = {8'hF0, 8'h43, 8'h10, 8'hF7};
        send_msg(1, m, 0);
        wait_idle(drop_c, sx_before);
        chk("gen_busy_drop", drop_c - last_push_cyc, 7);
        chk("sysex_through_gap", sx_before, 1);
        chk("sysex_cleared_idle", is_st_sysex, 0);
        chk("grant_gen_cleared", grant_gen, 0);

        // Simultaneous request: live first, gen at next IDLE.
        accept_log.delete();
        fork
            begin msg_t a; a = {8'h80, 8'h3C, 8'h40}; send_msg(0, a, 0); end
            begin msg_t b; b = {8'hF0, 8'h7E, 8'hF7}; send_msg(1, b, 0); end
        join
        wait_idle(drop_c, sx_before);
        chk("simul_order_len", accept_log.size(), 2);
        if (accept_log.size() == 2) begin
            chk("simul_first_live", accept_log[0], 0);
            chk("simul_second_gen", accept_log[1], 1);
        end

        // Live burst with gen waiting: gen forced in on the fifth grant.
        accept_log.delete();
        fork
            begin
                for (int k = 0; k < 5; k++) begin
                    msg_t a;
                    a = {8'hB0, 8'(k)};
                    send_msg(0, a, 0);
                end
            end
            begin msg_t b; b = {8'hC0, 8'h05}; send_msg(1, b, 0); end
        join
        wait_idle(drop_c, sx_before);
        chk("burst_order_len", accept_log.size(), 6);
        if (accept_log.size() == 6)
            for (int k = 0; k < 6; k++) chk($sformatf("burst_owner_%0d", k), accept_log[k], exp_order[k]);

        // Stall timeout: gen sends F0 then goes silent.
        m = {8'hF0};
        drive_byte(1, 8'hF0, 1'b0);
        wait_accept(1, m, 0, ok);
        @(posedge reg_clk);
        #1;
        gen_valid = 1'b0;
        br_c = last_push_cyc;
        n = 0;
        do begin
            @(negedge reg_clk);
            n++;
        end while (!abort_pulse && n < 1200);
        chk("abort_cycle", cyc - br_c, 1031);
        chk("abort_state", {busy, is_st_sysex, midibyte_nr, midi_in_data, grant_gen, byteready}, 0);
        @(negedge reg_clk);
        chk("abort_width", abort_pulse, 0);
        repeat (20) @(negedge reg_clk);
        chk("abort_no_bytes", exp_q.size(), 0);

        // Reset in the GAP after byte 0 of a three-byte message.
        @(posedge reg_clk);
        #1;
        m = {8'h80, 8'h40, 8'h00};
        drive_byte(0, 8'h80, 1'b0);
        wait_accept(0, m, 0, ok);
        @(posedge reg_clk);
        #1;
        live_data = 8'h40;
        repeat (2) @(posedge reg_clk);
        #1;
        reset_reg = 1'b1;
        #1;
        chk("reset_mid_message", all_outs(), 0);
        live_valid = 1'b0;
        repeat (2) @(posedge reg_clk);
        #1;
        reset_reg = 1'b0;
        @(posedge reg_clk);
        #1;
        m = {8'h90, 8'h11, 8'h22};
        send_msg(0, m, 0);
        wait_idle(drop_c, sx_before);

        // Randomized traffic from both sources.
        fork
            begin
                for (int k = 0; k < 8; k++) begin
                    send_msg(0, rand_msg(), 12);
                    repeat ($urandom_range(0, 15)) @(posedge reg_clk);
                    #1;
                end
            end
            begin
                for (int k = 0; k < 8; k++) begin
                    send_msg(1, rand_msg(), 12);
                    repeat ($urandom_range(0, 15)) @(posedge reg_clk);
                    #1;
                end
            end
        join
        wait_idle(drop_c, sx_before);
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge reg_clk);
            n++;
        end
        chk("queue_drained", exp_q.size(), 0);
        chk("idle_at_end", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/midi_byte_arbiter.md
Name: midi_byte_arbiter

Overview:
- Shares the single MIDI byte-trigger path (byteready / midibyte_nr / midi_in_data / is_st_sysex) between two byte-stream sources:
  - Live: the UART MIDI parser.
  - Gen: the internal sysex/patch-send generator.
- Grants whole messages, never interleaves bytes of two messages, and enforces a minimum spacing between byteready pulses so the downstream trigger/delay chain and note stack settle.
- Includes a starvation guard for the generator and a mid-message stall timeout.

Parameters:
- GAP_CYCLES, 6, idle cycles inserted after every emitted byte (min 1).
- STALL_TIMEOUT, 1024, cycles the owner may hold valid low in GRANT before the message is aborted.
- MAX_LIVE_BURST, 4, consecutive live messages granted while gen waits before gen is forced in.

Ports:
- reg_clk  in  1  system clock; all logic on rising edge.
- reset_reg  in  1  asynchronous, active-high reset.
- live_valid  in  1  live source has a byte.
- live_data  in  8  live byte.
- live_last  in  1  byte is last of its message.
- live_ready  out  1  live byte accepted when valid&ready.
- gen_valid  in  1  generator has a byte.
- gen_data  in  8  generator byte.
- gen_last  in  1  last byte of message.
- gen_ready  out  1  generator byte accepted when valid&ready.
- byteready  out  1  one-cycle pulse: midi_in_data/midibyte_nr valid.
- midi_in_data  out  8  current byte.
- midibyte_nr  out  8  index of byte in message (status = 0).
- is_st_sysex  out  1  current message began with 8'hF0.
- grant_gen  out  1  generator owns the path.
- busy  out  1  state != IDLE.
- abort_pulse  out  1  one-cycle pulse on stall-timeout abort.

Behaviour:
- Reset (async, immediate): every output 0, state IDLE, all counters 0. Reset mid-message discards the message; sources restart from their status byte.
- States: IDLE, GRANT, EMIT, GAP.
- IDLE:
  - If live_valid|gen_valid, choose the owner and go to GRANT next cycle.
  - Gen is chosen if only gen_valid, or if gen_valid and burst_cnt == MAX_LIVE_BURST; otherwise live is chosen.
  - grant_gen registers the choice.
  - byte_idx clears to 0.
- GRANT:
  - The owner's ready is 1; the other source's ready is 0. Ready is 0 in all other states.
  - On owner valid: latch data into midi_in_data, byte_idx into midibyte_nr, and last into a last flag; go to EMIT.
  - On the byte_idx==0 accept, set is_st_sysex = (data == 8'hF0).
- EMIT:
  - byteready = 1 for exactly this cycle; byte_idx increments, saturating at 255.
  - Go to GAP with gap_cnt = GAP_CYCLES.
- GAP:
  - Decrement gap_cnt; at 1, go to GRANT if last flag = 0, else IDLE.
  - On the GAP→IDLE transition, clear is_st_sysex and grant_gen.
- Latency and spacing:
  - Accept to byteready is 1 cycle.
  - Minimum byteready period is GAP_CYCLES+2 (8 at default).
  - midi_in_data and midibyte_nr hold from EMIT until the next accept.
- Burst counter, updated at each IDLE arbitration:
  - Live chosen while gen_valid=1: burst_cnt+1, saturating.
  - Gen chosen, or gen_valid=0: burst_cnt = 0.
- Stall timeout:
  - In GRANT, stall_cnt increments each cycle the owner's valid=0; it clears on accept or on leaving GRANT.
  - When stall_cnt reaches STALL_TIMEOUT-1 with valid still 0: abort_pulse = 1 next cycle, go to IDLE, and clear midibyte_nr, midi_in_data, is_st_sysex and grant_gen. No byteready is issued.
- Simultaneous events:
  - A source asserting valid during EMIT or GAP waits; no byte is lost.
  - The non-owner's valid is ignored until IDLE.
  - A last byte followed immediately by the same source's next message re-arbitrates in IDLE (1 idle cycle minimum).
- Width rules:
  - gap_cnt is clog2(GAP_CYCLES+1) bits.
  - stall_cnt is clog2(STALL_TIMEOUT) bits.
  - burst_cnt is clog2(MAX_LIVE_BURST+1) bits.

Test Plan:
- Reset, then live sends 90 3C 64 (last on 64) → three byteready pulses 8 cycles apart; midibyte_nr 0,1,2; data 90,3C,64; is_st_sysex 0; busy drops 7 cycles after the third pulse.
- Gen sends F0 43 10 F7 → is_st_sysex = 1 from the first accept through the end of the GAP after F7, grant_gen = 1 throughout, midibyte_nr 0..3.
- live_valid and gen_valid rise on the same cycle → live granted. Gen waits with gen_ready = 0 and no interleaving; gen is granted at the next IDLE.
- Live streams 5 back-to-back messages while gen is valid → messages 1–4 are live, the 5th grant goes to gen, then live resumes.
- Gen sends F0, then holds valid low for 1024 cycles → abort_pulse for 1 cycle, busy = 0, is_st_sysex = 0, midibyte_nr = 0, no further byteready.
- Assert reset_reg during GAP of byte 1 of a 3-byte message → all outputs 0 immediately; after release, a new message starts at midibyte_nr 0.
